clkgen_ctrl: RTL and testbench

CLKGEN_CTRL -- requirements
Module: clkgen_ctrl

---
 rtl/clkgen_ctrl_pkg.sv | 26 ++
 rtl/clkgen_ctrl_if.sv | 25 ++
 rtl/clkgen_ctrl_cnt.sv | 31 +++
 rtl/clkgen_ctrl.sv | 162 ++++++++++++++++
 tb/tb_clkgen_ctrl.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/clkgen_ctrl_pkg.sv
// Shared types for the clock-generator controller: command op codes, FSM states
// and the down-counter width.
package clkgen_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_SETDIV  = 2'd0,
    OP_SHIFT   = 2'd1,
    OP_STRETCH = 2'd2,
    OP_NOP     = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_SYNC = 2'd1,
    ST_RUN       = 2'd2,
    ST_SETTLE    = 2'd3
  } state_e;

  localparam int CNT_W = 8;

  // Counter load value for an n-cycle interval; saturates so n=0 never wraps.
  function automatic logic [CNT_W-1:0] minus_one(input logic [CNT_W-1:0] v);
    return (v == 8'd0) ? 8'd0 : v - 8'd1;
  endfunction

endpackage

// File: rtl/clkgen_ctrl_if.sv
// Command and generator-control bundle between a command source (master) and
// the clkgen_ctrl block (slave).
interface clkgen_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_arg;
  logic       sync;
  logic [5:0] clkdiv;
  logic       shift;
  logic       stretch;
  logic       done;
  logic       tmo_err;
  logic       tmo_clr;

  modport master (
    output cmd_valid, cmd_op, cmd_arg, sync, tmo_clr,
    input  cmd_ready, clkdiv, shift, stretch, done, tmo_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_arg, sync, tmo_clr,
    output cmd_ready, clkdiv, shift, stretch, done, tmo_err
  );
endinterface

// File: rtl/clkgen_ctrl_cnt.sv
// Loadable 8-bit down-counter that holds at zero; one instance times sync
// timeout, run length and divider settling.
module clkgen_ctrl_cnt
  import clkgen_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count_r;

  // Count register: load has priority, decrement stops at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= 8'd0;
    end else if (load) begin
      count_r <= load_val;
    end else if (dec && (count_r != 8'd0)) begin
      count_r <= count_r - 8'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == 8'd0);

endmodule

// File: rtl/clkgen_ctrl.sv
// Clock-generator controller: accepts SETDIV/SHIFT/STRETCH/NOP commands, aligns
// them to the generator sync pulse and drives registered control outputs.
module clkgen_ctrl
  import clkgen_ctrl_pkg::*;
#(
  parameter logic [5:0] DIV_INIT = 6'd2,
  parameter int         SETTLE   = 64,
  parameter int         SYNC_TMO = 255
) (
  input  logic         clk,
  input  logic         reset,
  clkgen_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] TMO_LOAD    = minus_one(8'(SYNC_TMO));
  localparam logic [CNT_W-1:0] SETTLE_LOAD = minus_one(8'(SETTLE));

  state_e     state_r, state_s;
  op_e        op_r, op_s;
  logic [7:0] arg_r, arg_s;
  logic [5:0] clkdiv_r, clkdiv_s;
  logic       shift_r, shift_s;
  logic       stretch_r, stretch_s;
  logic       done_r, done_s;
  logic       tmo_r, tmo_s;
  logic             cnt_load_s;
  logic [CNT_W-1:0] cnt_val_s;
  logic             cnt_dec_s;
  logic             cnt_zero_s;

  clkgen_ctrl_cnt u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load_s),
    .load_val (cnt_val_s),
    .dec      (cnt_dec_s),
    .zero     (cnt_zero_s)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state, counter control and next values of the registered outputs.
  always_comb begin
    state_s    = state_r;
    op_s       = op_r;
    arg_s      = arg_r;
    clkdiv_s   = clkdiv_r;
    shift_s    = 1'b0;
    stretch_s  = 1'b0;
    done_s     = 1'b0;
    tmo_s      = bus.tmo_clr ? 1'b0 : tmo_r;
    cnt_load_s = 1'b0;
    cnt_val_s  = 8'd0;
    cnt_dec_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          op_s  = op_e'(bus.cmd_op);
          arg_s = bus.cmd_arg;
          if ((op_e'(bus.cmd_op) == OP_NOP) ||
              ((op_e'(bus.cmd_op) != OP_SETDIV) && (bus.cmd_arg == 8'd0))) begin
            done_s = 1'b1;
          end else begin
            state_s    = ST_WAIT_SYNC;
            cnt_load_s = 1'b1;
            cnt_val_s  = TMO_LOAD;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT_SYNC: begin
        if (bus.sync || cnt_zero_s) begin
          // A missing sync is flagged but the command still runs.
          if (!bus.sync) begin
            tmo_s = 1'b1;
          end else begin
            tmo_s = tmo_s;
          end
          state_s = ST_RUN;
          case (op_r)
            OP_SETDIV: clkdiv_s = arg_r[5:0];
            OP_SHIFT: begin
              shift_s    = 1'b1;
              cnt_load_s = 1'b1;
              cnt_val_s  = minus_one(arg_r);
            end
            OP_STRETCH: begin
              stretch_s  = 1'b1;
              cnt_load_s = 1'b1;
              cnt_val_s  = minus_one(arg_r);
            end
            default: clkdiv_s = clkdiv_r;
          endcase
        end else begin
          cnt_dec_s = 1'b1;
        end
      end
      ST_RUN: begin
        if (op_r == OP_SETDIV) begin
          state_s    = ST_SETTLE;
          cnt_load_s = 1'b1;
          cnt_val_s  = SETTLE_LOAD;
        end else if (cnt_zero_s) begin
          state_s = ST_IDLE;
          done_s  = 1'b1;
        end else begin
          cnt_dec_s = 1'b1;
          shift_s   = (op_r == OP_SHIFT);
          stretch_s = (op_r == OP_STRETCH);
        end
      end
      ST_SETTLE: begin
        if (cnt_zero_s) begin
          state_s = ST_IDLE;
          done_s  = 1'b1;
        end else begin
          cnt_dec_s = 1'b1;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Command latch and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_r      <= OP_NOP;
      arg_r     <= 8'd0;
      clkdiv_r  <= DIV_INIT;
      shift_r   <= 1'b0;
      stretch_r <= 1'b0;
      done_r    <= 1'b0;
      tmo_r     <= 1'b0;
    end else begin
      op_r      <= op_s;
      arg_r     <= arg_s;
      clkdiv_r  <= clkdiv_s;
      shift_r   <= shift_s;
      stretch_r <= stretch_s;
      done_r    <= done_s;
      tmo_r     <= tmo_s;
    end
  end

  assign bus.cmd_ready = (state_r == ST_IDLE);
  assign bus.clkdiv    = clkdiv_r;
  assign bus.shift     = shift_r;
  assign bus.stretch   = stretch_r;
  assign bus.done      = done_r;
  assign bus.tmo_err   = tmo_r;

endmodule

// File: tb/tb_clkgen_ctrl.sv
// Directed vector bench for clkgen_ctrl: a command table with hand-derived
// cycle timings plus hand-written timeout, tmo_clr and mid-command reset sequences.
module tb_clkgen_ctrl;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  clkgen_ctrl_if bus();

  clkgen_ctrl #(
    .DIV_INIT (6'd2),
    .SETTLE   (64),
    .SYNC_TMO (255)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle numbers count edges after the acceptance edge; 0 means "never".
  typedef struct {
    logic [1:0] op;
    logic [7:0] arg;
    logic       sync_acc;
    int         sync_dly;
    int         exp_done;
    int         exp_shift_first;
    int         exp_shift_n;
    int         exp_stretch_first;
    int         exp_stretch_n;
    int         exp_div_cyc;
    int         exp_div;
    int         exp_tmo;
  } vec_t;

  vec_t vecs[8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [7:0] arg, input logic sync_acc);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_arg   = arg;
    bus.sync      = sync_acc;
    step();
    bus.cmd_valid = 1'b0;
    bus.sync      = 1'b0;
  endtask

  initial begin
    int  c, done_cyc, sf, sn, tf, tn, dc, rlow, ovl, bad;
    bit  seen;
    int  prev_div;

    errors = 0;
    checks = 0;
    //               op     arg    acc  dly done sf  sn tf   tn dc div    tmo
    vecs[0] = '{2'd3, 8'h55, 1'b0, 0,  1,   0,  0, 0,   0, 0, 32'h02, 0};
    vecs[1] = '{2'd1, 8'd5,  1'b0, 10, 16,  11, 5, 0,   0, 0, 32'h02, 0};
    vecs[2] = '{2'd0, 8'h1B, 1'b0, 1,  67,  0,  0, 0,   0, 2, 32'h1B, 0};
    vecs[3] = '{2'd2, 8'd3,  1'b0, 0,  259, 0,  0, 256, 3, 0, 32'h1B, 1};
    vecs[4] = '{2'd2, 8'd0,  1'b0, 0,  1,   0,  0, 0,   0, 0, 32'h1B, 1};
    vecs[5] = '{2'd1, 8'd2,  1'b1, 4,  7,   5,  2, 0,   0, 0, 32'h1B, 1};
    vecs[6] = '{2'd0, 8'h05, 1'b0, 2,  68,  0,  0, 0,   0, 3, 32'h05, 1};
    vecs[7] = '{2'd1, 8'd1,  1'b0, 1,  3,   2,  1, 0,   0, 0, 32'h05, 1};

    reset         = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'd3;
    bus.cmd_arg   = 8'd0;
    bus.sync      = 1'b0;
    bus.tmo_clr   = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();

    check("reset clkdiv",    int'(bus.clkdiv),    2);
    check("reset cmd_ready", int'(bus.cmd_ready), 1);
    check("reset shift",     int'(bus.shift),     0);
    check("reset stretch",   int'(bus.stretch),   0);
    check("reset done",      int'(bus.done),      0);
    check("reset tmo_err",   int'(bus.tmo_err),   0);

    for (int i = 0; i < 8; i++) begin
      prev_div = int'(bus.clkdiv);
      check($sformatf("v%0d ready before", i), int'(bus.cmd_ready), 1);
      issue(vecs[i].op, vecs[i].arg, vecs[i].sync_acc);
      c = 1; seen = 1'b0; done_cyc = 0;
      sf = 0; sn = 0; tf = 0; tn = 0; dc = 0; rlow = 0; ovl = 0;
      while (!seen && c <= 400) begin
        bus.sync = (c == vecs[i].sync_dly);
        if (bus.shift) begin
          if (sf == 0) sf = c;
          sn++;
        end
        if (bus.stretch) begin
          if (tf == 0) tf = c;
          tn++;
        end
        if (bus.shift && bus.stretch) ovl++;
        if (dc == 0 && int'(bus.clkdiv) != prev_div) dc = c;
        if (!bus.cmd_ready) rlow++;
        if (bus.done) begin
          seen = 1'b1;
          done_cyc = c;
        end
        step();
        c++;
      end
      bus.sync = 1'b0;
      check($sformatf("v%0d done_cycle", i),    done_cyc, vecs[i].exp_done);
      check($sformatf("v%0d done_width", i),    int'(bus.done), 0);
      check($sformatf("v%0d shift_first", i),   sf, vecs[i].exp_shift_first);
      check($sformatf("v%0d shift_len", i),     sn, vecs[i].exp_shift_n);
      check($sformatf("v%0d stretch_first", i), tf, vecs[i].exp_stretch_first);
      check($sformatf("v%0d stretch_len", i),   tn, vecs[i].exp_stretch_n);
      check($sformatf("v%0d overlap", i),       ovl, 0);
      check($sformatf("v%0d clkdiv_cycle", i),  dc, vecs[i].exp_div_cyc);
      check($sformatf("v%0d clkdiv", i),        int'(bus.clkdiv), vecs[i].exp_div);
      check($sformatf("v%0d tmo_err", i),       int'(bus.tmo_err), vecs[i].exp_tmo);
      check($sformatf("v%0d ready_low", i),     rlow, vecs[i].exp_done - 1);
    end

    // New timeout in the same cycle as tmo_clr: the set must win.
    issue(2'd2, 8'd1, 1'b0);
    for (int k = 1; k <= 254; k++) step();
    check("pre-timeout stretch", int'(bus.stretch), 0);
    bus.tmo_clr = 1'b1;
    step();
    bus.tmo_clr = 1'b0;
    check("set_wins tmo_err", int'(bus.tmo_err), 1);
    check("set_wins stretch", int'(bus.stretch), 1);
    step();
    check("set_wins done", int'(bus.done), 1);
    check("set_wins stretch off", int'(bus.stretch), 0);

    // Plain clear.
    bus.tmo_clr = 1'b1;
    step();
    bus.tmo_clr = 1'b0;
    check("tmo_clr clears", int'(bus.tmo_err), 0);
    step();
    check("tmo_err stays clear", int'(bus.tmo_err), 0);

    // Reset in the middle of a long SHIFT.
    issue(2'd1, 8'd200, 1'b0);
    for (int k = 1; k <= 50; k++) begin
      bus.sync = (k == 1);
      step();
    end
    bus.sync = 1'b0;
    check("mid shift active", int'(bus.shift), 1);
    #2;
    reset = 1'b1;
    #1;
    check("abort shift",   int'(bus.shift),     0);
    check("abort stretch", int'(bus.stretch),   0);
    check("abort done",    int'(bus.done),      0);
    check("abort clkdiv",  int'(bus.clkdiv),    2);
    check("abort ready",   int'(bus.cmd_ready), 1);
    step();
    reset = 1'b0;
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (bus.done || bus.shift) bad++;
    end
    check("no done after abort", bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
